// File: rtl/pattern_serializer_pkg.sv
//============================================================================
// pattern_serializer_pkg
//   Shared constants and types for the serial pattern path (transmitter and
//   detector side).
//   Revision: 1.0
//============================================================================
`default_nettype none

package pattern_serializer_pkg;

    // Default frame shared with the sequence detector
    localparam int                       DEFAULT_WIDTH   = 12;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PATTERN = 12'b1110_1101_1011;
    localparam int                       DEFAULT_GAP     = 2;

    // Transmitter FSM encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_t;

    // Larger of two integers, used to size the shared bit/gap counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_serializer_frame_shifter.sv
//============================================================================
// pattern_serializer_frame_shifter
//   Loadable WIDTH-bit left shifter. Load has priority over shift; zeros
//   enter at the LSB so the register drains to all-zero after WIDTH shifts.
//   Revision: 1.0
//============================================================================
`default_nettype none

module pattern_serializer_frame_shifter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_value,
    output logic             msb
);

    logic [WIDTH-1:0] shift_reg;

    // Frame register: parallel load or shift left by one, zero fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= load_value;
        end else if (shift) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shift_reg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/pattern_serializer.sv
//============================================================================
// pattern_serializer
//   Sends a fixed WIDTH-bit frame MSB-first, repeated 'count' times with
//   GAP idle cycles between frames. All outputs come straight from flops.
//   Revision: 1.0
//============================================================================
`default_nettype none

module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               GAP     = DEFAULT_GAP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] count,
    output logic       x_out,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    // One counter serves as bit index in SHIFT and gap index in GAP
    localparam int               CNT_W    = $clog2(max_int(WIDTH, GAP + 1));
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit               HAS_GAP  = (GAP > 0);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       frames_rem;

    // Control strobes from the next-state logic
    logic             load;
    logic             shift;
    logic             accept;
    logic             advance;
    logic             cnt_clr;

    // Next values of the registered status outputs
    logic             valid_d;
    logic             busy_d;
    logic             done_d;

    // The shifter has drained to zero whenever the FSM is not in SHIFT,
    // so its MSB flop is directly the serial output.
    pattern_serializer_frame_shifter #(
        .WIDTH (WIDTH)
    ) u_frame_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .shift      (shift),
        .load_value (PATTERN),
        .msb        (x_out)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        cnt_clr    = 1'b1;
        case (state)
            S_IDLE: begin
                // count of zero is a rejected request
                if (start && (count != 4'd0)) begin
                    next_state = S_SHIFT;
                    load       = 1'b1;
                    accept     = 1'b1;
                end
            end
            S_SHIFT: begin
                cnt_clr = 1'b0;
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (frames_rem == 4'd0) begin
                        // final shift leaves the register all-zero
                        next_state = S_IDLE;
                        shift      = 1'b1;
                    end else if (HAS_GAP) begin
                        next_state = S_GAP;
                        shift      = 1'b1;
                    end else begin
                        // back-to-back frame, no idle cycle
                        load    = 1'b1;
                        advance = 1'b1;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            S_GAP: begin
                cnt_clr = 1'b0;
                if (cnt == GAP_LAST) begin
                    cnt_clr    = 1'b1;
                    next_state = S_SHIFT;
                    load       = 1'b1;
                    advance    = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Next values of the status outputs, decoded from the upcoming state
    always_comb begin
        valid_d = (next_state == S_SHIFT);
        busy_d  = (next_state != S_IDLE);
        done_d  = (state == S_SHIFT) && (next_state == S_IDLE);
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            valid <= valid_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Shared bit/gap counter, restarted at every frame or gap boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frames still to send after the current one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_rem <= 4'd0;
        end else if (accept) begin
            frames_rem <= count - 4'd1;
        end else if (advance) begin
            frames_rem <= frames_rem - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_serializer.sv
//============================================================================
// tb_pattern_serializer
//   Scoreboard bench: expected per-cycle outputs are queued when a request
//   is driven and compared as the DUTs produce them. One DUT uses GAP=2,
//   the other GAP=0.
//   Revision: 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pattern_serializer;

    localparam int          W   = 12;
    localparam logic [11:0] PAT = 12'b1110_1101_1011;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    logic       start2 = 1'b0;
    logic [3:0] count2 = 4'd0;
    logic       x2, v2, b2, d2;

    logic       start0 = 1'b0;
    logic [3:0] count0 = 4'd0;
    logic       x0, v0, b0, d0;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n2    = 0;
    int         n0    = 0;

    // Expected {x_out, valid, busy, done} per cycle
    logic [3:0] q2[$];
    logic [3:0] q0[$];
    logic [3:0] e2, e0;

    // Shift-register check model on the serial line
    bit          sr_en = 1'b0;
    logic [11:0] sr    = 12'd0;
    int          sr_nb = 0;
    int          sr_hits = 0;

    pattern_serializer #(
        .WIDTH   (12),
        .PATTERN (12'hEDB),
        .GAP     (2)
    ) dut_gap2 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
        .count (count2),
        .x_out (x2),
        .valid (v2),
        .busy  (b2),
        .done  (d2)
    );

    pattern_serializer #(
        .WIDTH   (12),
        .PATTERN (12'hEDB),
        .GAP     (0)
    ) dut_gap0 (
        .clk   (clk),
        .reset (reset),
        .start (start0),
        .count (count0),
        .x_out (x0),
        .valid (v0),
        .busy  (b0),
        .done  (d0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int sel, input logic [3:0] e);
        if (sel == 0) q0.push_back(e);
        else          q2.push_back(e);
    endtask

    // Expected stream of one burst: frames, gaps between them, then done
    task automatic push_burst(input int sel, input int n, input int gap);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < W; i++)
                push_exp(sel, {PAT[W-1-i], 1'b1, 1'b1, 1'b0});
            if (f < n - 1)
                for (int g = 0; g < gap; g++)
                    push_exp(sel, 4'b0010);
        end
        push_exp(sel, 4'b0001);
    endtask

    task automatic push_idle(input int sel, input int k);
        for (int i = 0; i < k; i++)
            push_exp(sel, 4'b0000);
    endtask

    task automatic wait_drain(input int sel, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (((sel == 0) ? q0.size() : q2.size()) == 0) return;
            @(posedge clk);
        end
        #2;
        if (sel == 0) begin
            check_val("drain_timeout_gap0", q0.size(), 0);
            q0.delete();
        end else begin
            check_val("drain_timeout_gap2", q2.size(), 0);
            q2.delete();
        end
    endtask

    // Single-frame burst on the GAP=2 DUT, with line check model
    task automatic single_frame(input string tag);
        sr_hits = 0;
        sr_nb   = 0;
        sr      = 12'd0;
        sr_en   = 1'b1;
        push_burst(2, 1, 2);
        push_idle(2, 2);
        start2 = 1'b1;
        count2 = 4'd1;
        @(negedge clk);
        start2 = 1'b0;
        wait_drain(2, 40);
        sr_en = 1'b0;
        check_val(tag, sr_hits, 1);
    endtask

    // Scoreboard: compare one queued entry per DUT per cycle
    always @(posedge clk) begin
        #1;
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            check_val($sformatf("gap2_out[%0d]", n2), {28'd0, x2, v2, b2, d2}, {28'd0, e2});
            n2++;
        end
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check_val($sformatf("gap0_out[%0d]", n0), {28'd0, x0, v0, b0, d0}, {28'd0, e0});
            n0++;
        end
    end

    // Check model: counts windows of 12 valid bits equal to the frame
    always @(posedge clk) begin
        #2;
        if (sr_en && v2) begin
            sr = {sr[10:0], x2};
            sr_nb++;
            if (sr_nb >= 12 && sr == 12'hEDB) sr_hits++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_x_out", x2, 0);
        check_val("rst_valid", v2, 0);
        check_val("rst_busy",  b2, 0);
        check_val("rst_done",  d2, 0);
        check_val("rst_gap0_outs", {x0, v0, b0, d0}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame
        single_frame("single_frame_hits");
        repeat (2) @(negedge clk);

        // Three frames with gaps; starts at 5 and 13 ignored, start at 41 (done) accepted
        push_burst(2, 3, 2);
        push_burst(2, 1, 2);
        push_idle(2, 2);
        for (int c = 0; c <= 41; c++) begin
            start2 = (c == 0) || (c == 5) || (c == 13) || (c == 41);
            count2 = (c == 0) ? 4'd3 : 4'd1;
            @(negedge clk);
        end
        start2 = 1'b0;
        wait_drain(2, 60);
        repeat (2) @(negedge clk);

        // GAP=0, two contiguous frames
        push_burst(0, 2, 0);
        push_idle(0, 2);
        start0 = 1'b1;
        count0 = 4'd2;
        @(negedge clk);
        start0 = 1'b0;
        wait_drain(0, 60);
        repeat (2) @(negedge clk);

        // count=0 rejected, start held high
        push_idle(2, 20);
        start2 = 1'b1;
        count2 = 4'd0;
        repeat (20) @(negedge clk);
        start2 = 1'b0;
        wait_drain(2, 40);
        repeat (2) @(negedge clk);

        // Reset during a count=2 burst at cycle 6
        for (int i = 0; i < 6; i++)
            push_exp(2, {PAT[W-1-i], 1'b1, 1'b1, 1'b0});
        push_idle(2, 10);
        for (int c = 0; c <= 16; c++) begin
            start2 = (c == 0);
            count2 = 4'd2;
            if (c == 6) begin
                reset = 1'b0;
                #1;
                check_val("async_rst_x_out", x2, 0);
                check_val("async_rst_valid", v2, 0);
                check_val("async_rst_busy",  b2, 0);
                check_val("async_rst_done",  d2, 0);
            end
            if (c == 9) reset = 1'b1;
            @(negedge clk);
        end
        start2 = 1'b0;
        wait_drain(2, 40);
        repeat (2) @(negedge clk);

        // After reset release, behaves as from power-up
        single_frame("post_reset_hits");
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
